// File: rtl/rx_serial_writer.sv
// Serial receive front end: recovers 8N1 bytes from an asynchronous line and
// writes each good byte into the receive FIFO write port, flagging framing and
// overrun errors with sticky status bits.
module rx_serial_writer #(
    parameter int BIT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic       fifo_full,
    input  logic       clear_errors,
    output logic       w_enable,
    output logic [7:0] w_data,
    output logic       rx_busy,
    output logic       framing_error,
    output logic       overrun_error
);

    localparam int HALF = BIT_PERIOD / 2;
    localparam int TW   = $clog2(BIT_PERIOD);

    localparam logic [TW-1:0] HalfLoad = TW'(HALF - 1);
    localparam logic [TW-1:0] BitLoad  = TW'(BIT_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWrite
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    w_data_q, w_data_d;
    logic          fe_q, fe_d;
    logic          oe_q, oe_d;
    logic          s1_q, s2_q, s3_q;
    logic          set_fe, set_oe;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= serial_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            w_data_q  <= '0;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            w_data_q  <= w_data_d;
            fe_q      <= fe_d;
            oe_q      <= oe_d;
        end
    end

    // Next-state logic: bit timing, sampling at bit centres and error detection.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        w_data_d  = w_data_q;
        set_fe    = 1'b0;
        set_oe    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!s2_q && s3_q) begin
                    state_d = StStart;
                    timer_d = HalfLoad;
                end
            end
            StStart: begin
                if (timer_q == '0) begin
                    if (s2_q) begin
                        state_d = StIdle;  // glitch, not a real start bit
                    end else begin
                        state_d   = StData;
                        timer_d   = BitLoad;
                        bit_cnt_d = '0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StData: begin
                if (timer_q == '0) begin
                    shift_d[bit_cnt_q] = s2_q;
                    timer_d            = BitLoad;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StStop: begin
                if (timer_q == '0) begin
                    if (!s2_q) begin
                        set_fe  = 1'b1;
                        state_d = StIdle;
                    end else if (fifo_full) begin
                        set_oe  = 1'b1;  // byte dropped, never retried
                        state_d = StIdle;
                    end else begin
                        w_data_d = shift_q;
                        state_d  = StWrite;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A set in the same cycle as a clear wins.
        fe_d = set_fe | (fe_q & ~clear_errors);
        oe_d = set_oe | (oe_q & ~clear_errors);
    end

    // Outputs decoded from registered state.
    always_comb begin
        w_enable      = (state_q == StWrite);
        rx_busy       = (state_q != StIdle);
        w_data        = w_data_q;
        framing_error = fe_q;
        overrun_error = oe_q;
    end

endmodule

// File: tb/tb_rx_serial_writer.sv
// Directed bench for rx_serial_writer: table of single frames plus hand-written
// sequences for back-to-back frames, glitches, sticky overrun and mid-frame reset.
module tb_rx_serial_writer;

    localparam int BP   = 10;
    localparam int HALF = BP / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       fifo_full;
    logic       clear_errors;
    logic       w_enable;
    logic [7:0] w_data;
    logic       rx_busy;
    logic       framing_error;
    logic       overrun_error;

    rx_serial_writer #(.BIT_PERIOD(BP)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .fifo_full     (fifo_full),
        .clear_errors  (clear_errors),
        .w_enable      (w_enable),
        .w_data        (w_data),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: counts strobes and remembers the last two writes.
    int         we_count    = 0;
    int         last_we_cyc = 0;
    int         prev_we_cyc = 0;
    logic [7:0] last_data   = 8'h00;
    logic [7:0] prev_data   = 8'h00;
    int         busy_cnt    = 0;
    always @(negedge clk) begin
        if (w_enable) begin
            we_count    = we_count + 1;
            prev_we_cyc = last_we_cyc;
            last_we_cyc = cyc;
            prev_data   = last_data;
            last_data   = w_data;
        end
        if (rx_busy) busy_cnt = busy_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        start_cyc = cyc + 1;  // next posedge is the first to sample the start bit
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (BP) @(negedge clk);
        end
        serial_in = stop;
        repeat (BP) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       full;
        logic       exp_we;
        logic       exp_fe;
        logic       exp_oe;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];
    int   snap_we;
    int   snap_busy;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h34};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};

        rst          = 1'b1;
        serial_in    = 1'b1;
        fifo_full    = 1'b0;
        clear_errors = 1'b0;
        repeat (3) @(negedge clk);
        check("reset w_enable", 32'(w_enable), 32'd0);
        check("reset w_data", 32'(w_data), 32'h00);
        check("reset rx_busy", 32'(rx_busy), 32'd0);
        check("reset framing_error", 32'(framing_error), 32'd0);
        check("reset overrun_error", 32'(overrun_error), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frames from the table.
        for (int i = 0; i < 6; i++) begin
            fifo_full = vecs[i].full;
            snap_we   = we_count;
            send_frame(vecs[i].data, vecs[i].stop);
            repeat (5) @(negedge clk);
            fifo_full = 1'b0;
            check($sformatf("vec%0d write count", i), 32'(we_count - snap_we),
                  32'(vecs[i].exp_we));
            if (vecs[i].exp_we)
                check($sformatf("vec%0d latency", i), 32'(last_we_cyc - start_cyc + 1), 32'd98);
            check($sformatf("vec%0d w_data", i), 32'(w_data), 32'(vecs[i].exp_wdata));
            check($sformatf("vec%0d framing_error", i), 32'(framing_error),
                  32'(vecs[i].exp_fe));
            check($sformatf("vec%0d overrun_error", i), 32'(overrun_error),
                  32'(vecs[i].exp_oe));
            pulse_clear();
            check($sformatf("vec%0d cleared fe", i), 32'(framing_error), 32'd0);
            check($sformatf("vec%0d cleared oe", i), 32'(overrun_error), 32'd0);
        end

        // Back-to-back frames with no gap beyond the stop bit.
        snap_we = we_count;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        check("b2b write count", 32'(we_count - snap_we), 32'd2);
        check("b2b spacing", 32'(last_we_cyc - prev_we_cyc), 32'd100);
        check("b2b first data", 32'(prev_data), 32'h3C);
        check("b2b second data", 32'(last_data), 32'hFF);

        // 3-cycle glitch: busy for HALF cycles only, no write, no error.
        pulse_clear();
        repeat (3) @(negedge clk);
        snap_we   = we_count;
        snap_busy = busy_cnt;
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch write count", 32'(we_count - snap_we), 32'd0);
        check("glitch busy cycles", 32'(busy_cnt - snap_busy), 32'(HALF));
        check("glitch framing_error", 32'(framing_error), 32'd0);
        check("glitch overrun_error", 32'(overrun_error), 32'd0);

        // Overrun stays sticky across a later good frame.
        snap_we   = we_count;
        fifo_full = 1'b1;
        send_frame(8'h12, 1'b1);
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("overrun set", 32'(overrun_error), 32'd1);
        send_frame(8'h34, 1'b1);
        repeat (5) @(negedge clk);
        check("overrun seq writes", 32'(we_count - snap_we), 32'd1);
        check("overrun seq w_data", 32'(w_data), 32'h34);
        check("overrun sticky", 32'(overrun_error), 32'd1);

        // Framing error with set and clear in the same cycle: set wins.
        snap_we = we_count;
        fork
            send_frame(8'h55, 1'b0);
            begin
                // Stop sample edge is start_cyc + 96; hold clear across it.
                repeat (96) @(negedge clk);
                clear_errors = 1'b1;
                repeat (2) @(negedge clk);
                clear_errors = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("fe set beats clear", 32'(framing_error), 32'd1);
        check("fe seq no write", 32'(we_count - snap_we), 32'd0);
        check("fe seq w_data held", 32'(w_data), 32'h34);

        // Reset during data bit 4.
        snap_we   = we_count;
        serial_in = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            serial_in = i[0];
            repeat (BP) @(negedge clk);
        end
        serial_in = 1'b1;
        repeat (BP / 2) @(negedge clk);
        check("pre-reset busy", 32'(rx_busy), 32'd1);
        rst       = 1'b1;
        @(negedge clk);
        check("midreset w_enable", 32'(w_enable), 32'd0);
        check("midreset w_data", 32'(w_data), 32'h00);
        check("midreset rx_busy", 32'(rx_busy), 32'd0);
        check("midreset framing_error", 32'(framing_error), 32'd0);
        check("midreset overrun_error", 32'(overrun_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        check("midreset no write", 32'(we_count - snap_we), 32'd0);
        snap_we = we_count;
        send_frame(8'h81, 1'b1);
        repeat (5) @(negedge clk);
        check("post-reset write count", 32'(we_count - snap_we), 32'd1);
        check("post-reset w_data", 32'(w_data), 32'h81);
        check("post-reset latency", 32'(last_we_cyc - start_cyc + 1), 32'd98);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
